// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encoding and oversampling points.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OS_RATE   = 16;
    localparam int START_MID = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, mid-bit sampling, stop-bit check and done strobe.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic [2:0]      dbg_state
);

    // Output handshake: rx_done_tick is a single-cycle strobe with no back-pressure;
    // dout, frame_err and parity_err are valid on that cycle and hold until the next strobe.

    logic            rx_s;
    state_t          state_q, state_n;
    logic [4:0]      s_cnt_q, s_cnt_n;
    logic [3:0]      n_cnt_q, n_cnt_n;
    logic [DBIT-1:0] shreg_q, shreg_n;
    logic [DBIT-1:0] dout_n;
    logic            done_n;
    logic            fe_n;
`ifdef UART_RX_PARITY_EN
    logic            pbit_q, pbit_n;
    logic            pe_q, pe_n;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_n = state_q;
        s_cnt_n = s_cnt_q;
        n_cnt_n = n_cnt_q;
        shreg_n = shreg_q;
        dout_n  = dout;
        done_n  = 1'b0;
        fe_n    = frame_err;
`ifdef UART_RX_PARITY_EN
        pbit_n  = pbit_q;
        pe_n    = pe_q;
`endif
        case (state_q)
            // Start detection is level-based and does not wait for a tick.
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'(START_MID)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'(OS_RATE - 1)) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_cnt_q == 4'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_cnt_n = n_cnt_q + 4'd1;
                        end
                    end else begin
                        s_cnt_n = s_cnt_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'(OS_RATE - 1)) begin
                        pbit_n  = rx_s;
                        s_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'(SB_TICK - 1)) begin
                        dout_n  = shreg_q;
                        fe_n    = ~rx_s;
                        done_n  = 1'b1;
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        pe_n    = (^{shreg_q, pbit_q}) ^ PARITY_ODD;
`endif
                    end else begin
                        s_cnt_n = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            shreg_q      <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= 1'b0;
            pe_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            s_cnt_q      <= s_cnt_n;
            n_cnt_q      <= n_cnt_n;
            shreg_q      <= shreg_n;
            dout         <= dout_n;
            rx_done_tick <= done_n;
            frame_err    <= fe_n;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= pbit_n;
            pe_q         <= pe_n;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dbg_state = state_q;

endmodule
